// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: first-word-fall-through FIFO on an inferred simple dual-port BRAM.
// Handles the pointers, the occupancy count and the RAM's one-cycle read latency,
// so the head word sits on rd_data whenever empty is low.
// Optional build macro: BRAM_FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow
// registers. Without it both outputs are tied low.
module bram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LEVEL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LEVEL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PRIME = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr, r_ptr, rd_addr;
    logic [ADDR_WIDTH:0]   level_next;
    logic                  push, pop;

    assign push = wr & ~full;
    assign pop  = rd & ~empty;

    // Look one word ahead on a pop so the next head lands on rd_data right after it.
    assign rd_addr = pop ? r_ptr + ADDR_WIDTH'(1) : r_ptr;

    // RAM: write port plus registered read port. Nonblocking semantics give
    // read-first behaviour when the read and write addresses collide.
    always_ff @(posedge clk) begin
        if (push) mem[w_ptr] <= w_data;
        rd_data <= mem[rd_addr];
    end

    // Occupancy: +1 on push only, -1 on pop only.
    always_comb begin
        level_next = level;
        if (push && !pop)      level_next = level + LEVEL_ONE;
        else if (pop && !push) level_next = level - LEVEL_ONE;
    end

    // Pointers, level and the registered full flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            level <= '0;
            full  <= 1'b0;
        end else begin
            if (push) w_ptr <= w_ptr + ADDR_WIDTH'(1);
            if (pop)  r_ptr <= r_ptr + ADDR_WIDTH'(1);
            level <= level_next;
            full  <= (level_next == LEVEL_FULL);
        end
    end

    // Head-valid state register.
    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    // Next state and empty flag. PRIME covers the cycle the RAM spends fetching
    // a head word that was written while no valid head was on the output.
    always_comb begin
        state_next = state;
        empty      = 1'b1;
        case (state)
            EMPTY: begin
                if (push) state_next = PRIME;
            end
            PRIME: begin
                state_next = VALID;
            end
            VALID: begin
                empty = 1'b0;
                if (pop && level == LEVEL_ONE)
                    state_next = push ? PRIME : EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

`ifdef BRAM_FIFO_ERR_FLAGS_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr && full)  overflow  <= 1'b1;
            if (rd && empty) underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl (ADDR_WIDTH=3, DATA_WIDTH=8).
module tb_bram_fifo_ctrl;

    localparam int AW = 3;
    localparam int DW = 8;
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    localparam logic FLAGS = 1'b1;
`else
    localparam logic FLAGS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          wr, rd;
    logic [DW-1:0] w_data;
    logic [DW-1:0] rd_data;
    logic          full, empty, overflow, underflow;
    logic [AW:0]   level;

    int n_checks = 0;
    int n_errors = 0;

    bram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
        .rd_data(rd_data), .full(full), .empty(empty), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [DW-1:0] d);
        wr = 1'b1; w_data = d;
        step();
        wr = 1'b0;
    endtask

    logic [DW-1:0] q[$];
    logic [DW-1:0] nd;

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);

        // 1: single word latency
        push1(8'hA5);
        chk("t1_prime_empty", empty, 1);
        chk("t1_level", level, 1);
        step();
        chk("t1_valid_empty", empty, 0);
        chk("t1_data", rd_data, 8'hA5);
        rd = 1'b1; step(); rd = 1'b0;
        chk("t1_pop_empty", empty, 1);
        chk("t1_pop_level", level, 0);

        // 2: fill, ignored 9th push, back-to-back drain
        for (int i = 0; i < 8; i++) push1(DW'(i));
        chk("t2_full", full, 1);
        chk("t2_level", level, 8);
        push1(8'hFF);
        chk("t2_level_after_ovf", level, 8);
        chk("t2_ovf", overflow, FLAGS);
        rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_drain_empty", empty, 0);
            chk("t2_drain_data", rd_data, i);
            step();
        end
        rd = 1'b0;
        chk("t2_end_empty", empty, 1);
        chk("t2_end_level", level, 0);
        chk("t2_unf", underflow, 0);

        // 3: steady state wr&rd at level 4, pointers wrap
        for (int i = 0; i < 4; i++) begin
            push1(8'h10 + DW'(i));
            q.push_back(8'h10 + DW'(i));
        end
        step();
        chk("t3_level0", level, 4);
        wr = 1'b1; rd = 1'b1;
        for (int k = 0; k < 20; k++) begin
            nd = 8'h20 + DW'(k);
            w_data = nd;
            chk("t3_stream_data", rd_data, q.pop_front());
            chk("t3_stream_empty", empty, 0);
            q.push_back(nd);
            step();
        end
        wr = 1'b0;
        chk("t3_level", level, 4);
        for (int k = 0; k < 4; k++) begin
            chk("t3_tail_data", rd_data, q.pop_front());
            step();
        end
        rd = 1'b0;
        chk("t3_end_empty", empty, 1);
        chk("t3_end_level", level, 0);

        // 4: level 1 with simultaneous wr&rd goes through PRIME
        push1(8'h55);
        step();
        chk("t4_head", rd_data, 8'h55);
        chk("t4_level1", level, 1);
        wr = 1'b1; rd = 1'b1; w_data = 8'h66;
        step();
        wr = 1'b0; rd = 1'b0;
        chk("t4_prime_empty", empty, 1);
        chk("t4_prime_level", level, 1);
        step();
        chk("t4_new_empty", empty, 0);
        chk("t4_new_head", rd_data, 8'h66);
        rd = 1'b1; step(); rd = 1'b0;
        chk("t4_end_empty", empty, 1);

        // 5: wr&rd when full -> pop only; when empty -> push only
        for (int i = 0; i < 8; i++) push1(8'h30 + DW'(i));
        step();
        wr = 1'b1; rd = 1'b1; w_data = 8'h99;
        step();
        wr = 1'b0; rd = 1'b0;
        chk("t5_full_level", level, 7);
        chk("t5_full_flag", full, 0);
        chk("t5_full_head", rd_data, 8'h31);
        rd = 1'b1;
        for (int i = 0; i < 7; i++) step();
        rd = 1'b0;
        chk("t5_drained", empty, 1);
        chk("t5_drained_level", level, 0);
        wr = 1'b1; rd = 1'b1; w_data = 8'h77;
        step();
        wr = 1'b0; rd = 1'b0;
        chk("t5_empty_level", level, 1);
        chk("t5_empty_prime", empty, 1);
        step();
        chk("t5_empty_head", rd_data, 8'h77);
        chk("t5_empty_valid", empty, 0);

        // 6: sticky flags, then reset mid-stream
        step(); step();
        chk("t6_ovf_held", overflow, FLAGS);
        chk("t6_unf_held", underflow, FLAGS);
        push1(8'h01);
        push1(8'h02);
        wr = 1'b1; w_data = 8'h03;
        reset = 1'b1;
        step();
        reset = 1'b0; wr = 1'b0;
        chk("t6_rst_level", level, 0);
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_full", full, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_unf", underflow, 0);
        push1(8'hC3);
        step();
        chk("t6_post_head", rd_data, 8'hC3);
        chk("t6_post_level", level, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
